// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: issues LOAD / ALU commands to a register-file datapath, one per cycle.
// Define CMD_FIFO_EN to buffer commands in a 4-entry FIFO instead of a single holding register.
module alu_cmd_seq (
  input  logic        clk0,
  input  logic        rst_n0,
  input  logic        cmd_valid0,
  output logic        cmd_ready0,
  input  logic        cmd_kind0,
  input  logic [4:0]  cmd_ra0,
  input  logic [4:0]  cmd_rb0,
  input  logic [4:0]  cmd_rw0,
  input  logic [1:0]  cmd_aluc0,
  input  logic [31:0] cmd_imm0,
  input  logic        z0,
  input  logic        v0,
  output logic [4:0]  ra0,
  output logic [4:0]  rb0,
  output logic [4:0]  rw0,
  output logic        we0,
  output logic [31:0] rd0,
  output logic        s0,
  output logic [1:0]  aluc0,
  output logic        done0,
  output logic        zf0,
  output logic        vf0,
  output logic        halt0,
  input  logic        clear0,
  output logic [15:0] issued_cnt0
);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;
  localparam int CMD_W = 50;

  state_t      r_state;
  logic        r_halt, r_done, r_zf, r_vf, r_we, r_s;
  logic [4:0]  r_ra, r_rb, r_rw;
  logic [1:0]  r_aluc;
  logic [31:0] r_rd;
  logic [15:0] r_cnt;

  logic             w_halting, w_canIssue, w_push, w_bufEmpty, w_issue, w_pop, w_store;
  logic [CMD_W-1:0] w_inCmd, w_bufHead, w_issueCmd;

  // Command word layout: {kind, ra, rb, rw, aluc, imm}
  assign w_inCmd    = {cmd_kind0, cmd_ra0, cmd_rb0, cmd_rw0, cmd_aluc0, cmd_imm0};
  assign w_halting  = (r_state == ISSUE) && r_s && v0;
  assign w_canIssue = (r_state == IDLE) || ((r_state == ISSUE) && !w_halting);
  assign w_push     = cmd_valid0 && cmd_ready0;
  assign w_issue    = w_canIssue && (w_push || !w_bufEmpty);
  assign w_pop      = w_canIssue && !w_bufEmpty;
  // An empty buffer lets the incoming command bypass straight to issue.
  assign w_store    = w_push && !(w_canIssue && w_bufEmpty);
  assign w_issueCmd = w_bufEmpty ? w_inCmd : w_bufHead;

`ifdef CMD_FIFO_EN
  logic [CMD_W-1:0] r_fifo [4];
  logic [1:0]       r_wrPtr, r_rdPtr;
  logic [2:0]       r_count;

  assign w_bufEmpty = (r_count == 3'd0);
  assign w_bufHead  = r_fifo[r_rdPtr];
  assign cmd_ready0 = rst_n0 && (r_count != 3'd4);

  always_ff @(posedge clk0) begin
    if (!rst_n0) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_store) begin
        r_fifo[r_wrPtr] <= w_inCmd;
        r_wrPtr         <= r_wrPtr + 2'd1;
      end
      if (w_pop)
        r_rdPtr <= r_rdPtr + 2'd1;
      r_count <= r_count + {2'b00, w_store} - {2'b00, w_pop};
    end
  end
`else
  logic [CMD_W-1:0] r_held;
  logic             r_heldValid;

  assign w_bufEmpty = !r_heldValid;
  assign w_bufHead  = r_held;
  // The holding register only fills when a command arrives as an ALU op halts.
  assign cmd_ready0 = rst_n0 && (((r_state == IDLE) && !r_heldValid) || (r_state == ISSUE));

  always_ff @(posedge clk0) begin
    if (!rst_n0) begin
      r_held      <= '0;
      r_heldValid <= 1'b0;
    end else if (w_store) begin
      r_held      <= w_inCmd;
      r_heldValid <= 1'b1;
    end else if (w_pop) begin
      r_heldValid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk0) begin
    if (!rst_n0) begin
      r_state <= IDLE;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
      r_zf    <= 1'b0;
      r_vf    <= 1'b0;
      r_cnt   <= 16'd0;
      r_we    <= 1'b0;
      r_s     <= 1'b0;
      r_ra    <= 5'd0;
      r_rb    <= 5'd0;
      r_rw    <= 5'd0;
      r_aluc  <= 2'd0;
      r_rd    <= 32'd0;
    end else begin
      r_done <= (r_state == ISSUE);
      if (r_state == ISSUE)
        r_cnt <= r_cnt + 16'd1;
      if (clear0)
        r_vf <= 1'b0;
      if ((r_state == ISSUE) && r_s) begin
        r_zf <= z0;
        r_vf <= v0;
      end

      r_we   <= 1'b0;
      r_s    <= 1'b0;
      r_ra   <= 5'd0;
      r_rb   <= 5'd0;
      r_rw   <= 5'd0;
      r_aluc <= 2'd0;
      r_rd   <= 32'd0;

      if (w_issue) begin
        r_state <= ISSUE;
        r_we    <= 1'b1;
        r_s     <= w_issueCmd[49];
        r_rw    <= w_issueCmd[38:34];
        if (w_issueCmd[49]) begin
          r_ra   <= w_issueCmd[48:44];
          r_rb   <= w_issueCmd[43:39];
          r_aluc <= w_issueCmd[33:32];
        end else begin
          r_rd <= w_issueCmd[31:0];
        end
      end else if (w_halting) begin
        r_state <= HALT;
        r_halt  <= 1'b1;
      end else if (r_state == ISSUE) begin
        r_state <= IDLE;
      end else if ((r_state == HALT) && clear0) begin
        r_state <= IDLE;
        r_halt  <= 1'b0;
      end
    end
  end

  assign ra0         = r_ra;
  assign rb0         = r_rb;
  assign rw0         = r_rw;
  assign we0         = r_we;
  assign rd0         = r_rd;
  assign s0          = r_s;
  assign aluc0       = r_aluc;
  assign done0       = r_done;
  assign zf0         = r_zf;
  assign vf0         = r_vf;
  assign halt0       = r_halt;
  assign issued_cnt0 = r_cnt;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed testbench for alu_cmd_seq; expected values are hand-computed per step.
// Works with or without CMD_FIFO_EN (only cmd_ready0 in HALT differs).
module tb_alu_cmd_seq;

  logic        clk0 = 1'b0;
  logic        rst_n0;
  logic        cmd_valid0, cmd_ready0, cmd_kind0;
  logic [4:0]  cmd_ra0, cmd_rb0, cmd_rw0;
  logic [1:0]  cmd_aluc0;
  logic [31:0] cmd_imm0;
  logic        z0, v0;
  logic [4:0]  ra0, rb0, rw0;
  logic        we0, s0, done0, zf0, vf0, halt0, clear0;
  logic [31:0] rd0;
  logic [1:0]  aluc0;
  logic [15:0] issued_cnt0;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int doneCount = 0;
  int weStart, doneStart;

  alu_cmd_seq dut (
    .clk0(clk0), .rst_n0(rst_n0),
    .cmd_valid0(cmd_valid0), .cmd_ready0(cmd_ready0), .cmd_kind0(cmd_kind0),
    .cmd_ra0(cmd_ra0), .cmd_rb0(cmd_rb0), .cmd_rw0(cmd_rw0),
    .cmd_aluc0(cmd_aluc0), .cmd_imm0(cmd_imm0),
    .z0(z0), .v0(v0),
    .ra0(ra0), .rb0(rb0), .rw0(rw0), .we0(we0), .rd0(rd0), .s0(s0), .aluc0(aluc0),
    .done0(done0), .zf0(zf0), .vf0(vf0), .halt0(halt0), .clear0(clear0),
    .issued_cnt0(issued_cnt0)
  );

  always #5 clk0 = ~clk0;

  // Count write-enable and done cycles at the inactive edge.
  always @(negedge clk0) begin
    if (we0 === 1'b1) weCount++;
    if (done0 === 1'b1) doneCount++;
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic applyStimulus(input logic kind, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw, input logic [1:0] aluc, input logic [31:0] imm);
    cmd_kind0  = kind;
    cmd_ra0    = ra;
    cmd_rb0    = rb;
    cmd_rw0    = rw;
    cmd_aluc0  = aluc;
    cmd_imm0   = imm;
    cmd_valid0 = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n0 = 1'b0; cmd_valid0 = 1'b0; cmd_kind0 = 1'b0;
    cmd_ra0 = 5'd0; cmd_rb0 = 5'd0; cmd_rw0 = 5'd0; cmd_aluc0 = 2'd0; cmd_imm0 = 32'd0;
    z0 = 1'b0; v0 = 1'b0; clear0 = 1'b0;

    $display("[TB] reset");
    tick(); tick();
    checkOutput("rst_ready", cmd_ready0, 0);
    checkOutput("rst_we", we0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_cnt", issued_cnt0, 0);
    checkOutput("rst_halt", halt0, 0);
    checkOutput("rst_flags", {zf0, vf0}, 0);
    rst_n0 = 1'b1;
    #1;
    checkOutput("idle_ready", cmd_ready0, 1);

    $display("[TB] gapped LOAD r1=5, LOAD r2=4, SUB r3");
    weStart = weCount; doneStart = doneCount;
    applyStimulus(0, 0, 0, 1, 0, 32'd5);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t1_we", we0, 1);
    checkOutput("t1_s", s0, 0);
    checkOutput("t1_rw", rw0, 1);
    checkOutput("t1_rd", rd0, 5);
    checkOutput("t1_rarb", {ra0, rb0, aluc0}, 0);
    checkOutput("t1_done_early", done0, 0);
    tick();
    checkOutput("t1_done", done0, 1);
    checkOutput("t1_idle_we", we0, 0);
    checkOutput("t1_idle_rdrw", {rd0, rw0}, 0);
    checkOutput("t1_cnt1", issued_cnt0, 1);
    applyStimulus(0, 0, 0, 2, 0, 32'd4);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t1_rd2", rd0, 4);
    checkOutput("t1_rw2", rw0, 2);
    tick();
    checkOutput("t1_cnt2", issued_cnt0, 2);
    applyStimulus(1, 1, 2, 3, 1, 32'hDEAD_BEEF);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t1_alu_we", we0, 1);
    checkOutput("t1_alu_s", s0, 1);
    checkOutput("t1_alu_ra", ra0, 1);
    checkOutput("t1_alu_rb", rb0, 2);
    checkOutput("t1_alu_rw", rw0, 3);
    checkOutput("t1_alu_aluc", aluc0, 1);
    checkOutput("t1_alu_rd", rd0, 0);
    tick();
    checkOutput("t1_alu_done", done0, 1);
    checkOutput("t1_cnt3", issued_cnt0, 3);
    checkOutput("t1_zf", zf0, 0);
    checkOutput("t1_vf", vf0, 0);
    checkOutput("t1_after_we", we0, 0);
    tick();
    checkOutput("t1_done_once", done0, 0);
    checkOutput("t1_we_cycles", weCount - weStart, 3);
    checkOutput("t1_done_pulses", doneCount - doneStart, 3);

    $display("[TB] back-to-back LOAD r4=66, LOAD r5=21, ADD r6");
    applyStimulus(0, 0, 0, 4, 0, 32'd66);
    tick();
    checkOutput("t2_we1", we0, 1);
    checkOutput("t2_rd1", rd0, 66);
    applyStimulus(0, 0, 0, 5, 0, 32'd21);
    tick();
    checkOutput("t2_we2", we0, 1);
    checkOutput("t2_rd2", rd0, 21);
    checkOutput("t2_done2", done0, 1);
    applyStimulus(1, 4, 5, 6, 0, 32'd0);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t2_we3", we0, 1);
    checkOutput("t2_alu", {s0, ra0, rb0, rw0, aluc0}, {1'b1, 5'd4, 5'd5, 5'd6, 2'd0});
    tick();
    checkOutput("t2_we_off", we0, 0);
    checkOutput("t2_cnt", issued_cnt0, 6);

    $display("[TB] LOAD r7=33, LOAD r8=33, SUB r9 with z0=1");
    applyStimulus(0, 0, 0, 7, 0, 32'd33);
    tick();
    applyStimulus(0, 0, 0, 8, 0, 32'd33);
    tick();
    applyStimulus(1, 7, 8, 9, 1, 32'd0);
    tick(); cmd_valid0 = 1'b0;
    z0 = 1'b1;
    checkOutput("t3_alu_rw", rw0, 9);
    tick();
    z0 = 1'b0;
    checkOutput("t3_zf", zf0, 1);
    checkOutput("t3_vf", vf0, 0);
    checkOutput("t3_cnt", issued_cnt0, 9);

    $display("[TB] overflow halt with queued command");
    applyStimulus(0, 0, 0, 10, 0, 32'h7FFF_FFFF);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t4_rd_max", rd0, 32'h7FFF_FFFF);
    tick();
    checkOutput("t4_load_keeps_zf", zf0, 1);
    checkOutput("t4_cnt10", issued_cnt0, 10);
    applyStimulus(0, 0, 0, 11, 0, 32'd1);
    tick();
    applyStimulus(1, 10, 11, 12, 0, 32'd0);
    tick();
    v0 = 1'b1;
    applyStimulus(0, 0, 0, 13, 0, 32'h0000_ABCD);
    checkOutput("t4_alu_s", s0, 1);
    checkOutput("t4_ready_issue", cmd_ready0, 1);
    tick(); cmd_valid0 = 1'b0; v0 = 1'b0;
    checkOutput("t4_halt", halt0, 1);
    checkOutput("t4_vf", vf0, 1);
    checkOutput("t4_zf", zf0, 0);
    checkOutput("t4_done", done0, 1);
    checkOutput("t4_cnt12", issued_cnt0, 12);
    checkOutput("t4_halt_we", we0, 0);
`ifdef CMD_FIFO_EN
    checkOutput("t4_halt_ready", cmd_ready0, 1);
`else
    checkOutput("t4_halt_ready", cmd_ready0, 0);
`endif
    tick(); tick();
    checkOutput("t4_still_halt", halt0, 1);
    checkOutput("t4_no_issue", we0, 0);
    checkOutput("t4_cnt_hold", issued_cnt0, 12);
    checkOutput("t4_no_done", done0, 0);
    clear0 = 1'b1;
    tick(); clear0 = 1'b0;
    checkOutput("t4_cleared_halt", halt0, 0);
    checkOutput("t4_cleared_vf", vf0, 0);
    checkOutput("t4_idle_we", we0, 0);
    tick();
    checkOutput("t4_queued_we", we0, 1);
    checkOutput("t4_queued_rw", rw0, 13);
    checkOutput("t4_queued_rd", rd0, 32'h0000_ABCD);
    checkOutput("t4_queued_s", s0, 0);
    tick();
    checkOutput("t4_queued_done", done0, 1);
    checkOutput("t4_cnt13", issued_cnt0, 13);

    $display("[TB] reset during ISSUE");
    applyStimulus(0, 0, 0, 14, 0, 32'd1);
    tick(); cmd_valid0 = 1'b0;
    checkOutput("t5_issue", we0, 1);
    rst_n0 = 1'b0;
    tick();
    checkOutput("t5_no_done", done0, 0);
    checkOutput("t5_cnt", issued_cnt0, 0);
    checkOutput("t5_we", we0, 0);
    checkOutput("t5_ready", cmd_ready0, 0);
    rst_n0 = 1'b1;
    tick();
    checkOutput("t5_no_late_done", done0, 0);
    checkOutput("t5_ready_back", cmd_ready0, 1);

    $display("[TB] 65536 LOADs, counter wrap");
    applyStimulus(0, 0, 0, 15, 0, 32'd7);
    for (int i = 0; i < 65536; i++) tick();
    checkOutput("t6_cnt_max", issued_cnt0, 16'hFFFF);
    checkOutput("t6_we", we0, 1);
    cmd_valid0 = 1'b0;
    tick();
    checkOutput("t6_cnt_wrap", issued_cnt0, 0);
    checkOutput("t6_done", done0, 1);
    tick();
    checkOutput("t6_we_off", we0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
